// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset release controller.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  // Width that holds the largest terminal count of any sequencer counter.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// Consecutive-high filter on pll_lock; lock_ok strobes on the edge that
// samples the LOCK_FILTER-th consecutive high.
module lock_filter
  import reset_seq_pkg::*;
#(
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic pll_lock,
  input  logic clear,
  output logic lock_ok
);

  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  // Count consecutive high samples, saturating at LOCK_FILTER.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (clear || !pll_lock) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != CNT_W'(LOCK_FILTER)) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
    lock_ok = !clear && pll_lock && (lock_cnt_q == CNT_W'(LOCK_FILTER - 1));
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (reset) lock_cnt_q <= '0;
    else       lock_cnt_q <= lock_cnt_d;
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release controller: lock filter, reset stretch, staged
// active-low release, and software reset handshake.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pll_lock,
  input  logic                  sw_reset_req,
  output logic                  sw_reset_ack,
  output logic [NUM_STAGES-1:0] reset_n_out,
  output logic                  ready
);

  localparam int unsigned CNT_W = cnt_width(LOCK_FILTER, HOLD_CYCLES, STAGE_GAP);
  localparam int unsigned STG_W = $clog2(NUM_STAGES + 1);
  localparam logic [NUM_STAGES-1:0] STAGE0 = NUM_STAGES'(1);

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STG_W-1:0]       stage_q, stage_d;
  logic [NUM_STAGES-1:0]  rst_n_q, rst_n_d;
  logic                   ready_q, ready_d;
  logic                   ack_q, ack_d;
  logic                   lock_ok;

  lock_filter #(
    .LOCK_FILTER (LOCK_FILTER),
    .CNT_W       (CNT_W)
  ) u_lock_filter (
    .clock    (clock),
    .reset    (reset),
    .pll_lock (pll_lock),
    .clear    (state_q != HOLD),
    .lock_ok  (lock_ok)
  );

  // Next-state and output logic; lock loss outranks the software request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_n_d = rst_n_q;
    ready_d = ready_q;
    ack_d   = 1'b0;
    if (state_q == HOLD) begin
      if (lock_ok) begin
        state_d = STRETCH;
        cnt_d   = '0;
      end
    end else if (!pll_lock) begin
      state_d = HOLD;
      cnt_d   = '0;
      stage_d = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        STRETCH: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_d   = '0;
            stage_d = STG_W'(1);
            rst_n_d = STAGE0;
            if (NUM_STAGES == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
            cnt_d   = '0;
            stage_d = stage_q + 1'b1;
            // Thermometer fill: released bits are always a contiguous run from bit 0.
            rst_n_d = (rst_n_q << 1) | STAGE0;
            if (stage_q == STG_W'(NUM_STAGES - 1)) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (sw_reset_req) begin
            state_d = STRETCH;
            cnt_d   = '0;
            stage_d = '0;
            rst_n_d = '0;
            ready_d = 1'b0;
            ack_d   = 1'b1;
          end
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  end

  assign reset_n_out  = rst_n_q;
  assign ready        = ready_q;
  assign sw_reset_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default-parameter instance and a
// NUM_STAGES=1/STAGE_GAP=1 instance share stimulus and are checked
// every cycle against a timeline model of the release schedule.
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset, pll_lock, sw_reset_req;
  logic       ack0, rdy0, ack1, rdy1;
  logic [2:0] rn0;
  logic [0:0] rn1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  reset_sequencer #(
    .NUM_STAGES  (3),
    .LOCK_FILTER (8),
    .HOLD_CYCLES (16),
    .STAGE_GAP   (4)
  ) dut0 (
    .clock        (clock),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .sw_reset_req (sw_reset_req),
    .sw_reset_ack (ack0),
    .reset_n_out  (rn0),
    .ready        (rdy0)
  );

  reset_sequencer #(
    .NUM_STAGES  (1),
    .LOCK_FILTER (8),
    .HOLD_CYCLES (16),
    .STAGE_GAP   (1)
  ) dut1 (
    .clock        (clock),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .sw_reset_req (sw_reset_req),
    .sw_reset_ack (ack1),
    .reset_n_out  (rn1),
    .ready        (rdy1)
  );

  // Model: either filtering lock (run length m_lr) or sequencing, where
  // m_t is edges since the sequence started and outputs follow from m_t.
  localparam int unsigned LF = 8;
  localparam int unsigned HC = 16;
  int unsigned m_ns [2] = '{3, 1};
  int unsigned m_gap[2] = '{4, 1};
  bit          m_act[2] = '{0, 0};
  int unsigned m_t  [2] = '{0, 0};
  int unsigned m_lr [2] = '{0, 0};
  bit          m_ack[2] = '{0, 0};

  function automatic int unsigned m_rel(input int d);
    int unsigned r;
    if (!m_act[d] || m_t[d] < HC) return 0;
    r = 1 + (m_t[d] - HC) / m_gap[d];
    return (r > m_ns[d]) ? m_ns[d] : r;
  endfunction

  task automatic model_edge(input bit r, input bit l, input bit q);
    for (int d = 0; d < 2; d++) begin
      bit running;
      running  = (m_rel(d) == m_ns[d]);
      m_ack[d] = 1'b0;
      if (r) begin
        m_act[d] = 1'b0;
        m_lr[d]  = 0;
      end else if (!m_act[d]) begin
        if (l) begin
          m_lr[d]++;
          if (m_lr[d] == LF) begin
            m_act[d] = 1'b1;
            m_t[d]   = 0;
            m_lr[d]  = 0;
          end
        end else begin
          m_lr[d] = 0;
        end
      end else if (!l) begin
        m_act[d] = 1'b0;
        m_lr[d]  = 0;
      end else if (running && q) begin
        m_t[d]   = 0;
        m_ack[d] = 1'b1;
      end else if (m_t[d] < 1000000) begin
        m_t[d]++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rn0",  8'(rn0),  8'((32'd1 << m_rel(0)) - 1));
    chk("rdy0", 8'(rdy0), 8'(m_rel(0) == m_ns[0]));
    chk("ack0", 8'(ack0), 8'(m_ack[0]));
    chk("rn1",  8'(rn1),  8'((32'd1 << m_rel(1)) - 1));
    chk("rdy1", 8'(rdy1), 8'(m_rel(1) == m_ns[1]));
    chk("ack1", 8'(ack1), 8'(m_ack[1]));
  endtask

  task automatic step(input bit r, input bit l, input bit q);
    @(negedge clock);
    reset        = r;
    pll_lock     = l;
    sw_reset_req = q;
    @(posedge clock);
    model_edge(r, l, q);
    #1;
    check_all();
  endtask

  initial begin
    int ack_edge;
    bit seen;
    reset        = 1'b1;
    pll_lock     = 1'b0;
    sw_reset_req = 1'b0;

    // Reset with lock high, then the nominal release timeline.
    step(1, 1, 0);
    step(1, 1, 0);
    chk("reset_rn0",  8'(rn0),  8'h00);
    chk("reset_rdy0", 8'(rdy0), 8'h00);
    chk("reset_ack0", 8'(ack0), 8'h00);
    for (int i = 1; i <= 40; i++) begin
      step(0, 1, 0);
      if (i == 23) chk("e23_rn0", 8'(rn0), 8'h00);
      if (i == 24) begin
        chk("e24_rn0",  8'(rn0),  8'h01);
        chk("e24_rdy1", 8'(rdy1), 8'h01);
        chk("e24_rn1",  8'(rn1),  8'h01);
      end
      if (i == 28) chk("e28_rn0", 8'(rn0), 8'h03);
      if (i == 31) chk("e31_rdy0", 8'(rdy0), 8'h00);
      if (i == 32) begin
        chk("e32_rn0",  8'(rn0),  8'h07);
        chk("e32_rdy0", 8'(rdy0), 8'h01);
      end
    end

    // Lock glitch after five high samples restarts the filter.
    step(1, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    step(0, 0, 0);
    for (int j = 1; j <= 40; j++) begin
      step(0, 1, 0);
      if (j == 23) chk("glitch_e23_rn0", 8'(rn0), 8'h00);
      if (j == 24) chk("glitch_e24_rn0", 8'(rn0), 8'h01);
    end

    // Lock loss in RUN, then full re-sequence.
    step(0, 0, 0);
    chk("loss_rn0",  8'(rn0),  8'h00);
    chk("loss_rdy0", 8'(rdy0), 8'h00);
    chk("loss_ack0", 8'(ack0), 8'h00);
    for (int j = 1; j <= 40; j++) begin
      step(0, 1, 0);
      if (j == 32) chk("reseq_e32_rn0", 8'(rn0), 8'h07);
    end

    // Software reset from RUN: skips the lock filter.
    step(0, 1, 1);
    chk("sw_ack0", 8'(ack0), 8'h01);
    chk("sw_rn0",  8'(rn0),  8'h00);
    for (int j = 1; j <= 30; j++) begin
      step(0, 1, 0);
      if (j == 1)  chk("sw_ack0_drop", 8'(ack0), 8'h00);
      if (j == 15) chk("sw_e15_rn0",   8'(rn0),  8'h00);
      if (j == 16) chk("sw_e16_rn0",   8'(rn0),  8'h01);
      if (j == 24) chk("sw_e24_rdy0",  8'(rdy0), 8'h01);
    end

    // Request raised during RELEASE: accepted only once RUN is reached.
    step(1, 1, 0);
    for (int i = 1; i <= 26; i++) step(0, 1, 0);
    seen     = 1'b0;
    ack_edge = 0;
    for (int k = 27; k <= 80 && !seen; k++) begin
      step(0, 1, 1);
      if (ack0 === 1'b1) begin
        seen     = 1'b1;
        ack_edge = k;
      end
    end
    chk("late_ack_edge", 8'(ack_edge), 8'd33);
    step(0, 1, 0);

    // Reset together with a request mid-RELEASE.
    step(1, 1, 0);
    for (int i = 1; i <= 26; i++) step(0, 1, 0);
    step(1, 1, 1);
    chk("rst_req_rn0",  8'(rn0),  8'h00);
    chk("rst_req_rdy0", 8'(rdy0), 8'h00);
    chk("rst_req_ack0", 8'(ack0), 8'h00);
    chk("rst_req_ack1", 8'(ack1), 8'h00);
    step(0, 1, 0);

    // Random lock drops, requests and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 29) != 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
